// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the LCD bus-cycle initiator: FSM encoding, default
// phase timing and the position of the controller busy flag.
package lcd_bus_pkg;

    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_STROBE_CYC = 16;
    localparam int DEF_HOLD_CYC   = 2;
    localparam int DEF_MAX_POLLS  = 255;
    localparam int BUSY_BIT       = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_P_SETUP  = 3'd4,
        ST_P_STROBE = 3'd5,
        ST_P_HOLD   = 3'd6,
        ST_DONE     = 3'd7
    } busState_t;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_bus_master_if.sv
// Request/response handshake plus peripheral bus pins of the LCD bus master.
// The master modport is the initiator's view; slave is the requester/bus side.
interface lcd_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic       req_rnw;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       timeout;
    logic       nCS;
    logic       nWR;
    logic       nRD;
    logic       RS;
    logic [7:0] db_out;
    logic       db_oe;
    logic [7:0] db_in;

    modport master (
        input  req_valid, req_rs, req_rnw, req_data, db_in,
        output req_ready, rsp_valid, rsp_data, timeout,
        output nCS, nWR, nRD, RS, db_out, db_oe
    );

    modport slave (
        output req_valid, req_rs, req_rnw, req_data, db_in,
        input  req_ready, rsp_valid, rsp_data, timeout,
        input  nCS, nWR, nRD, RS, db_out, db_oe
    );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing one bus phase. A load of N makes 'expired' high
// during the N-th cycle after the load; the count then parks at zero.
module lcd_phase_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Reloading on expiry is what chains phases back to back without a gap.
    assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/lcd_bus_master.sv
// Bus-cycle initiator for the LCD path: turns byte requests into timed
// nCS/nWR/nRD/RS cycles and optionally polls the busy flag after each write.
module lcd_bus_master
    import lcd_bus_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int POLL_EN    = 1,
    parameter int MAX_POLLS  = DEF_MAX_POLLS
) (
    input  logic             clk,
    input  logic             rst,
    lcd_bus_master_if.master bus
);
    localparam int PHASE_W = $clog2(maxOf3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
    localparam int POLL_W  = $clog2(MAX_POLLS + 1);

    busState_t         state;
    logic              rnwReg;
    logic              gapReg;
    logic              busyReg;
    logic [7:0]        sampleReg;
    logic [POLL_W-1:0] pollCnt;
    logic              timerLoad;
    logic [PHASE_W-1:0] timerValue;
    logic              phaseDone;

    lcd_phase_timer #(.WIDTH(PHASE_W)) phaseTimer (
        .clk     (clk),
        .rst     (rst),
        .load    (timerLoad),
        .value   (timerValue),
        .expired (phaseDone)
    );

    // The timer is (re)loaded on the same edge the FSM enters the phase it times.
    always_comb begin
        timerLoad  = 1'b0;
        timerValue = PHASE_W'(SETUP_CYC);
        case (state)
            ST_IDLE:     timerLoad = bus.req_valid && bus.req_ready;
            ST_SETUP: begin
                timerLoad  = phaseDone;
                timerValue = PHASE_W'(STROBE_CYC);
            end
            ST_STROBE: begin
                timerLoad  = phaseDone;
                timerValue = PHASE_W'(HOLD_CYC);
            end
            ST_HOLD:     timerLoad = phaseDone && !rnwReg && (POLL_EN != 0);
            ST_P_SETUP: begin
                timerLoad = gapReg || phaseDone;
                if (!gapReg) timerValue = PHASE_W'(STROBE_CYC);
            end
            ST_P_STROBE: begin
                timerLoad  = phaseDone;
                timerValue = PHASE_W'(HOLD_CYC);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rnwReg        <= 1'b0;
            gapReg        <= 1'b0;
            busyReg       <= 1'b0;
            sampleReg     <= '0;
            pollCnt       <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.timeout   <= 1'b0;
            bus.nCS       <= 1'b1;
            bus.nWR       <= 1'b1;
            bus.nRD       <= 1'b1;
            bus.RS        <= 1'b0;
            bus.db_out    <= '0;
            bus.db_oe     <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        rnwReg        <= bus.req_rnw;
                        bus.req_ready <= 1'b0;
                        bus.nCS       <= 1'b0;
                        bus.RS        <= bus.req_rs;
                        bus.db_oe     <= ~bus.req_rnw;
                        bus.db_out    <= bus.req_data;
                        state         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phaseDone) begin
                        bus.nRD <= ~rnwReg;
                        bus.nWR <= rnwReg;
                        state   <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (phaseDone) begin
                        sampleReg <= bus.db_in;
                        bus.nWR   <= 1'b1;
                        bus.nRD   <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (phaseDone) begin
                        if (!rnwReg && (POLL_EN != 0)) begin
                            // First poll follows the write with nCS still low.
                            gapReg     <= 1'b0;
                            pollCnt    <= POLL_W'(1);
                            bus.RS     <= 1'b0;
                            bus.db_oe  <= 1'b0;
                            bus.db_out <= '0;
                            state      <= ST_P_SETUP;
                        end else begin
                            if (rnwReg) begin
                                bus.rsp_valid <= 1'b1;
                                bus.rsp_data  <= sampleReg;
                            end
                            bus.nCS    <= 1'b1;
                            bus.RS     <= 1'b0;
                            bus.db_oe  <= 1'b0;
                            bus.db_out <= '0;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_P_SETUP: begin
                    if (gapReg) begin
                        gapReg  <= 1'b0;
                        bus.nCS <= 1'b0;
                    end else if (phaseDone) begin
                        bus.nRD <= 1'b0;
                        state   <= ST_P_STROBE;
                    end
                end
                ST_P_STROBE: begin
                    if (phaseDone) begin
                        busyReg <= bus.db_in[BUSY_BIT];
                        bus.nRD <= 1'b1;
                        state   <= ST_P_HOLD;
                    end
                end
                ST_P_HOLD: begin
                    if (phaseDone) begin
                        bus.nCS <= 1'b1;
                        if (busyReg && (pollCnt < POLL_W'(MAX_POLLS))) begin
                            pollCnt <= pollCnt + 1'b1;
                            gapReg  <= 1'b1;
                            state   <= ST_P_SETUP;
                        end else begin
                            bus.timeout <= busyReg;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    bus.req_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_master.sv
// Randomised bench for lcd_bus_master: two instances (no poll / poll with
// MAX_POLLS=4) traced cycle by cycle against a phase-arithmetic reference.
module tb_lcd_bus_master;
    localparam int S = 2, T = 16, H = 2;
    localparam int B = S + T + H;
    localparam int MAXP_A = 255, MAXP_B = 4;
    localparam logic [7:0] IDLE_VEC = 8'b1110_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_bus_master_if busA ();
    lcd_bus_master_if busB ();

    lcd_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .POLL_EN(0), .MAX_POLLS(MAXP_A))
        dutA (.clk(clk), .rst(rst), .bus(busA));
    lcd_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .POLL_EN(1), .MAX_POLLS(MAXP_B))
        dutB (.clk(clk), .rst(rst), .bus(busB));

    logic [1:0] tbValid, tbRs, tbRnw;
    logic [7:0] tbData [2];
    logic [7:0] tbDb   [2];
    logic [7:0] rspExp [2];
    int checks = 0;
    int errors = 0;

    assign busA.req_valid = tbValid[0];
    assign busA.req_rs    = tbRs[0];
    assign busA.req_rnw   = tbRnw[0];
    assign busA.req_data  = tbData[0];
    assign busA.db_in     = tbDb[0];
    assign busB.req_valid = tbValid[1];
    assign busB.req_rs    = tbRs[1];
    assign busB.req_rnw   = tbRnw[1];
    assign busB.req_data  = tbData[1];
    assign busB.db_in     = tbDb[1];

    // Observed vector: {nCS, nWR, nRD, RS, db_oe, rsp_valid, timeout, req_ready}
    function automatic logic [7:0] obsVec(input int sel);
        if (sel == 0)
            return {busA.nCS, busA.nWR, busA.nRD, busA.RS, busA.db_oe, busA.rsp_valid, busA.timeout, busA.req_ready};
        return {busB.nCS, busB.nWR, busB.nRD, busB.RS, busB.db_oe, busB.rsp_valid, busB.timeout, busB.req_ready};
    endfunction

    function automatic logic [7:0] obsDout(input int sel);
        return (sel == 0) ? busA.db_out : busB.db_out;
    endfunction

    function automatic logic [7:0] obsRsp(input int sel);
        return (sel == 0) ? busA.rsp_data : busB.rsp_data;
    endfunction

    // Reference: user cycle of B cycles, then polls of B cycles separated by one
    // nCS-high gap, then one DONE cycle, then idle.
    function automatic int doneCycle(input int nPolls);
        return (nPolls == 0) ? B : B + (nPolls - 1) * (B + 1) + B;
    endfunction

    function automatic logic [7:0] expVec(input int c, input bit rnw, input bit rs, input int nPolls, input bit tmo);
        int dc, r;
        logic cs, wr, rd, rsO, oe, rv, to, rdy;
        dc = doneCycle(nPolls);
        cs = 1; wr = 1; rd = 1; rsO = 0; oe = 0; rv = 0; to = 0; rdy = 0;
        if (c < B) begin
            cs = 0; rsO = rs; oe = !rnw;
            if (c >= S && c < S + T) begin
                if (rnw) rd = 0; else wr = 0;
            end
        end else if (c < dc) begin
            r = (c - B) % (B + 1);
            if (r < B) begin
                cs = 0;
                if (r >= S && r < S + T) rd = 0;
            end
        end else if (c == dc) begin
            rv = rnw; to = tmo;
        end else begin
            rdy = 1;
        end
        return {cs, wr, rd, rsO, oe, rv, to, rdy};
    endfunction

    task automatic run_txn(input int sel, input bit rnw, input bit rs, input logic [7:0] data,
                           input logic [7:0] rdByte, input int nBusy, input bit keepValid,
                           output int csLow, output int wrLow, output int rdLow, output int rdFalls,
                           output int csHighBusy, output int rspPulses, output int tmoPulses,
                           output int readyEdge, output int tailHigh);
        int nPolls, dc, maxP, r, p;
        bit tmo;
        logic [7:0] got, expv, dbv;
        logic prevRd;
        maxP = (sel == 1) ? MAXP_B : MAXP_A;
        if (rnw || sel == 0) begin nPolls = 0; tmo = 0; end
        else if (nBusy >= maxP) begin nPolls = maxP; tmo = 1; end
        else begin nPolls = nBusy + 1; tmo = 0; end
        dc = doneCycle(nPolls);
        csLow = 0; wrLow = 0; rdLow = 0; rdFalls = 0; csHighBusy = 0;
        rspPulses = 0; tmoPulses = 0; readyEdge = -1; tailHigh = 0; prevRd = 1;
        got = obsVec(sel);
        checks++;
        if (got[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept sel=%0d: req_ready=%b, required 1", sel, got[0]);
        end
        tbValid[sel] = 1'b1; tbRs[sel] = rs; tbRnw[sel] = rnw; tbData[sel] = data;
        @(posedge clk);
        for (int c = 0; c <= dc + 1; c++) begin
            @(negedge clk);
            got  = obsVec(sel);
            expv = expVec(c, rnw, rs, nPolls, tmo);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL trace sel=%0d c=%0d: got %b, required %b (nCS,nWR,nRD,RS,oe,rv,to,rdy)", sel, c, got, expv);
            end
            if (expv[3]) begin
                checks++;
                if (obsDout(sel) !== data) begin
                    errors++;
                    $display("FAIL db_out sel=%0d c=%0d: got %h, required %h", sel, c, obsDout(sel), data);
                end
            end
            checks++;
            if (!got[6] && !got[5]) begin
                errors++;
                $display("FAIL both_strobes sel=%0d c=%0d: nWR=%b nRD=%b, required not both 0", sel, c, got[6], got[5]);
            end
            checks++;
            if (got[7] && (!got[6] || !got[5])) begin
                errors++;
                $display("FAIL strobe_without_cs sel=%0d c=%0d: nCS=1 nWR=%b nRD=%b, required strobes 1", sel, c, got[6], got[5]);
            end
            if (!got[7]) csLow++;
            if (!got[6]) wrLow++;
            if (!got[5]) rdLow++;
            if (prevRd && !got[5]) rdFalls++;
            prevRd = got[5];
            if (got[7] && !got[0]) csHighBusy++;
            if (got[2]) rspPulses++;
            if (got[1]) tmoPulses++;
            if (got[0] && readyEdge < 0) readyEdge = c + 1;
            tailHigh = got[7] ? tailHigh + 1 : 0;
            // Meaningful read data only on the last strobe cycle of each read.
            dbv = 8'($urandom);
            if (rnw && c == S + T - 1) dbv = rdByte;
            else if (c >= B && c < dc) begin
                r = (c - B) % (B + 1);
                p = (c - B) / (B + 1) + 1;
                if (r == S + T - 1) dbv = (p <= nBusy) ? (dbv | 8'h80) : (dbv & 8'h7F);
            end
            tbDb[sel] = dbv;
            if (c == dc + 1) begin
                tbValid[sel] = keepValid;
            end else begin
                tbValid[sel] = keepValid ? 1'b1 : 1'($urandom_range(0, 1));
                tbRs[sel]    = 1'($urandom_range(0, 1));
                tbRnw[sel]   = 1'($urandom_range(0, 1));
                tbData[sel]  = 8'($urandom);
            end
        end
        if (rnw) rspExp[sel] = rdByte;
        checks++;
        if (obsRsp(sel) !== rspExp[sel]) begin
            errors++;
            $display("FAIL rsp_data sel=%0d: got %h, required %h", sel, obsRsp(sel), rspExp[sel]);
        end
        $display("txn sel=%0d %s rs=%0d data=%h rd=%h busy=%0d polls=%0d timeout=%0d", sel,
                 rnw ? "read " : "write", rs, data, rdByte, nBusy, nPolls, tmo);
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst = 1'b1;
        tbValid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            got = obsVec(s);
            checks++;
            if (got !== IDLE_VEC) begin
                errors++;
                $display("FAIL reset_outputs sel=%0d: got %b, required %b", s, got, IDLE_VEC);
            end
            checks++;
            if (obsDout(s) !== 8'h00 || obsRsp(s) !== 8'h00) begin
                errors++;
                $display("FAIL reset_data sel=%0d: db_out=%h rsp_data=%h, required 00/00", s, obsDout(s), obsRsp(s));
            end
            rspExp[s] = 8'h00;
        end
        tbValid = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_write_cmd();
        int csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail;
        run_txn(0, 1'b0, 1'b0, 8'h38, 8'h00, 0, 1'b0, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
        checks++;
        if (csL !== 20 || wrL !== 16 || rdL !== 0) begin
            errors++;
            $display("FAIL write_cmd_widths: nCS low %0d nWR low %0d nRD low %0d, required 20/16/0", csL, wrL, rdL);
        end
        checks++;
        if (rdyE !== 22) begin
            errors++;
            $display("FAIL write_cmd_latency: next accept edge %0d, required 22", rdyE);
        end
    endtask

    task automatic test_read();
        int csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail;
        run_txn(0, 1'b1, 1'b1, 8'h00, 8'h5A, 0, 1'b0, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
        checks++;
        if (rdL !== 16 || wrL !== 0 || rv !== 1) begin
            errors++;
            $display("FAIL read_strobe: nRD low %0d nWR low %0d rsp pulses %0d, required 16/0/1", rdL, wrL, rv);
        end
        checks++;
        if (busA.rsp_data !== 8'h5A) begin
            errors++;
            $display("FAIL read_data: got %h, required 5a", busA.rsp_data);
        end
    endtask

    task automatic test_poll();
        int csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail;
        run_txn(1, 1'b0, 1'b1, 8'h41, 8'h00, 3, 1'b0, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
        checks++;
        // Three inter-poll gaps plus the DONE cycle are the only busy nCS-high cycles.
        if (rdF !== 4 || csH !== 4 || rv !== 0 || to !== 0 || wrL !== 16) begin
            errors++;
            $display("FAIL poll_busy3: polls %0d gaps+done %0d rsp %0d timeout %0d nWR low %0d, required 4/4/0/0/16",
                     rdF, csH, rv, to, wrL);
        end
    endtask

    task automatic test_timeout();
        int csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail;
        run_txn(1, 1'b0, 1'b0, 8'hC3, 8'h00, 50, 1'b0, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
        checks++;
        if (rdF !== 4 || to !== 1 || rv !== 0) begin
            errors++;
            $display("FAIL poll_timeout: polls %0d timeout pulses %0d rsp %0d, required 4/1/0", rdF, to, rv);
        end
        checks++;
        // B write + 3*(B+1) + B final poll + DONE, then the idle cycle.
        if (rdyE !== 105) begin
            errors++;
            $display("FAIL poll_timeout_latency: next accept edge %0d, required 105", rdyE);
        end
    endtask

    task automatic test_reset_midcycle();
        int csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail;
        logic [7:0] got;
        tbValid[0] = 1'b1; tbRnw[0] = 1'b0; tbRs[0] = 1'b1; tbData[0] = 8'hA5;
        @(posedge clk);
        repeat (6) @(negedge clk);
        tbValid[0] = 1'b0;
        got = obsVec(0);
        checks++;
        if (got[6] !== 1'b0 || got[3] !== 1'b1) begin
            errors++;
            $display("FAIL midcycle_in_strobe: nWR=%b db_oe=%b, required 0/1", got[6], got[3]);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        got = obsVec(0);
        checks++;
        if (got !== IDLE_VEC) begin
            errors++;
            $display("FAIL midcycle_reset: got %b, required %b", got, IDLE_VEC);
        end
        rspExp[0] = 8'h00;
        rspExp[1] = 8'h00;
        rst = 1'b0;
        run_txn(0, 1'b0, 1'b1, 8'h3C, 8'h00, 0, 1'b0, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
        checks++;
        if (wrL !== 16 || csL !== 20) begin
            errors++;
            $display("FAIL after_reset_write: nWR low %0d nCS low %0d, required 16/20", wrL, csL);
        end
    endtask

    task automatic test_back_to_back();
        int csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail;
        run_txn(0, 1'b1, 1'b0, 8'h00, 8'hC7, 0, 1'b1, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
        checks++;
        if (tail < 2) begin
            errors++;
            $display("FAIL b2b_turnaround_a1: nCS high %0d cycles, required >=2", tail);
        end
        run_txn(0, 1'b0, 1'b1, 8'h9E, 8'h00, 0, 1'b1, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
        checks++;
        if (tail < 2) begin
            errors++;
            $display("FAIL b2b_turnaround_a2: nCS high %0d cycles, required >=2", tail);
        end
        run_txn(0, 1'b0, 1'b0, 8'h01, 8'h00, 0, 1'b0, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
        run_txn(1, 1'b0, 1'b1, 8'h55, 8'h00, 1, 1'b1, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
        checks++;
        if (tail < 2) begin
            errors++;
            $display("FAIL b2b_turnaround_b: nCS high %0d cycles, required >=2", tail);
        end
        run_txn(1, 1'b1, 1'b0, 8'h00, 8'h3E, 0, 1'b0, csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
    endtask

    task automatic test_random();
        int csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail;
        int sel, nBusy, expStrobes;
        bit rnw;
        for (int i = 0; i < 24; i++) begin
            sel   = $urandom_range(0, 1);
            rnw   = 1'($urandom_range(0, 1));
            nBusy = $urandom_range(0, 5);
            run_txn(sel, rnw, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), nBusy, 1'b0,
                    csL, wrL, rdL, rdF, csH, rv, to, rdyE, tail);
            expStrobes = 1;
            if (sel == 1 && !rnw) expStrobes += (nBusy >= MAXP_B) ? MAXP_B : nBusy + 1;
            checks++;
            if (rdF + ((wrL > 0) ? 1 : 0) !== expStrobes) begin
                errors++;
                $display("FAIL random_strobes i=%0d: %0d strobes, required %0d", i, rdF + ((wrL > 0) ? 1 : 0), expStrobes);
            end
        end
    endtask

    initial begin
        tbValid = '0; tbRs = '0; tbRnw = '0;
        tbData[0] = '0; tbData[1] = '0; tbDb[0] = '0; tbDb[1] = '0;
        rspExp[0] = '0; rspExp[1] = '0;
        test_reset();
        test_write_cmd();
        test_read();
        test_poll();
        test_timeout();
        test_reset_midcycle();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
